// File: rtl/fifo_read_drain_if.sv
// Downstream valid/ready stream carrying words drained from the async FIFO.
//   m_valid : word present on m_data (driven by the drain block)
//   m_data  : head word of the drain buffer
//   m_ready : downstream accepts the word on this edge
// master = drain block side, slave = downstream consumer side.
interface fifo_read_drain_if #(
  parameter int DSIZE = 8
);
  logic             m_valid;
  logic [DSIZE-1:0] m_data;
  logic             m_ready;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_read_drain.sv
// Read-side consumer of the asynchronous FIFO. Pops words while a slot is
// free in a 2-entry skid buffer (head H, tail T) and presents them as a
// valid/ready stream. Counts words accepted downstream.
//   rclk, rrst : read clock, synchronous active-high reset
//   en         : pop enable (buffered words still drain when low)
//   rempty     : FIFO empty flag
//   rdata      : FIFO head word (first-word-fall-through)
//   rinc       : FIFO pop strobe (combinational)
//   m          : output stream (m_valid / m_data / m_ready)
//   occ        : buffer occupancy 0..2
//   word_cnt   : accepted-word counter, wraps
module fifo_read_drain #(
  parameter int DSIZE = 8,
  parameter int CNT_W = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             en,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  fifo_read_drain_if.master m,
  output logic [1:0]       occ,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [DSIZE-1:0] h;
  logic [DSIZE-1:0] t;
  logic             acc;

  // Pop decision looks only at registered occupancy, never at m_ready,
  // so downstream ready has no combinational path into the FIFO.
  assign rinc      = !rrst && en && !rempty && (state != FULL);
  assign acc       = m.m_valid && m.m_ready;
  assign m.m_valid = (state != EMPTY);
  assign m.m_data  = h;
  assign occ       = state;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state    <= EMPTY;
      h        <= '0;
      t        <= '0;
      word_cnt <= '0;
    end else begin
      if (acc) word_cnt <= word_cnt + CNT_W'(1);
      // rdata is only ever captured under rinc, so FIFO garbage while
      // empty can never land in H or T.
      case (state)
        EMPTY: begin
          if (rinc) begin
            h     <= rdata;
            state <= ONE;
          end
        end
        ONE: begin
          if (rinc && acc) begin
            h <= rdata;                // head leaves, new word replaces it
          end else if (rinc) begin
            t     <= rdata;
            state <= FULL;
          end else if (acc) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (acc) begin
            h     <= t;                // promote tail; no pop possible here
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
